pll_lock_supervisor: RTL and testbench

- Multi-channel PLL/MMCM lock supervisor; successor to the single-PLL 10 ms retry watchdog in the clock manager.
- Per channel it:
  - drives the PLL reset, debounces the lock input, and retries on timeout;
  - declares a fault after a configurable retry count;
  - re-arms automatically on lock loss.
- Runs on the free-running board clock domain, upstream of the main_clk and ADC dclk wizards. Reports per-channel ready/fault plus an aggregate all_ready.

---
 rtl/pll_lock_supervisor.sv | 209 ++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Multi-channel PLL/MMCM lock supervisor: drives each PLL reset, debounces its
// lock, retries on timeout, latches a fault after too many retries.
module pll_lock_supervisor #(
  parameter int NUM_CH             = 3,
  parameter int RETRY_CYCLES       = 1000000,
  parameter int RST_PULSE_CYCLES   = 100,
  parameter int LOCK_STABLE_CYCLES = 1000,
  parameter int MAX_RETRIES        = 15,
  parameter int CNT_W              = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       locked_in,
  input  logic [NUM_CH-1:0]       force_rst,
  input  logic [NUM_CH-1:0]       clear_fault,
  output logic [NUM_CH-1:0]       pll_rst,
  output logic [NUM_CH-1:0]       ch_ready,
  output logic [NUM_CH-1:0]       ch_fault,
  output logic                    all_ready,
  output logic [NUM_CH-1:0]       loss_pulse,
  output logic [NUM_CH*CNT_W-1:0] retry_cnt,
  output logic [NUM_CH*CNT_W-1:0] loss_cnt
);

  localparam int RST_W   = (RST_PULSE_CYCLES > 1)   ? $clog2(RST_PULSE_CYCLES)   : 1;
  localparam int RETRY_W = (RETRY_CYCLES > 1)       ? $clog2(RETRY_CYCLES)       : 1;
  localparam int STAB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0]        MAX_RETRY_L = 32'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_DIS,
    ST_RST,
    ST_WAIT,
    ST_STAB,
    ST_READY,
    ST_FAULT
  } state_t;

  // Two-flop synchroniser; only lock_s_reg is ever used for decisions.
  logic [NUM_CH-1:0] lock_meta_reg;
  logic [NUM_CH-1:0] lock_s_reg;
  logic              all_ready_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_reg <= '0;
      lock_s_reg    <= '0;
    end else begin
      lock_meta_reg <= locked_in;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t             state_reg, state_next;
      logic [RST_W-1:0]   rst_tmr_reg, rst_tmr_next;
      logic [RETRY_W-1:0] retry_tmr_reg, retry_tmr_next;
      logic [STAB_W-1:0]  stab_reg, stab_next;
      logic [CNT_W-1:0]   retry_cnt_reg, retry_cnt_next;
      logic [CNT_W-1:0]   loss_cnt_reg, loss_cnt_next;
      logic [CNT_W-1:0]   retry_inc;
      logic               timeout;
      logic               loss_pulse_reg, loss_pulse_next;
      logic               pll_rst_reg, ch_ready_reg, ch_fault_reg;

      always_comb begin
        state_next      = state_reg;
        rst_tmr_next    = rst_tmr_reg;
        retry_tmr_next  = retry_tmr_reg;
        stab_next       = stab_reg;
        retry_cnt_next  = retry_cnt_reg;
        loss_cnt_next   = loss_cnt_reg;
        loss_pulse_next = 1'b0;
        retry_inc       = (retry_cnt_reg == '1) ? retry_cnt_reg : retry_cnt_reg + 1'b1;
        timeout         = (retry_tmr_reg == RETRY_LAST);

        if (!ch_enable[gi]) begin
          state_next = ST_DIS;
        end else if (force_rst[gi] && (state_reg != ST_DIS)) begin
          // A forced restart also takes precedence over a coincident timeout.
          state_next     = ST_RST;
          rst_tmr_next   = '0;
          retry_tmr_next = '0;
          if (state_reg == ST_FAULT) begin
            retry_cnt_next = '0;
          end
        end else begin
          case (state_reg)
            ST_DIS: begin
              state_next     = ST_RST;
              rst_tmr_next   = '0;
              retry_tmr_next = '0;
              retry_cnt_next = '0;
            end
            ST_RST: begin
              if (rst_tmr_reg == RST_LAST) begin
                state_next = ST_WAIT;
              end else begin
                rst_tmr_next = rst_tmr_reg + 1'b1;
              end
            end
            ST_WAIT, ST_STAB: begin
              if (timeout) begin
                retry_cnt_next = retry_inc;
                if ((MAX_RETRY_L != 32'd0) && (32'(retry_inc) >= MAX_RETRY_L)) begin
                  state_next = ST_FAULT;
                end else begin
                  state_next     = ST_RST;
                  rst_tmr_next   = '0;
                  retry_tmr_next = '0;
                end
              end else begin
                // The retry window spans WAIT and STAB; a lock glitch does not extend it.
                retry_tmr_next = retry_tmr_reg + 1'b1;
                if (state_reg == ST_WAIT) begin
                  if (lock_s_reg[gi]) begin
                    state_next = ST_STAB;
                    stab_next  = '0;
                  end
                end else if (!lock_s_reg[gi]) begin
                  state_next = ST_WAIT;
                end else if (stab_reg == STAB_LAST) begin
                  state_next     = ST_READY;
                  retry_cnt_next = '0;
                end else begin
                  stab_next = stab_reg + 1'b1;
                end
              end
            end
            ST_READY: begin
              if (!lock_s_reg[gi]) begin
                state_next      = ST_RST;
                rst_tmr_next    = '0;
                retry_tmr_next  = '0;
                loss_pulse_next = 1'b1;
                loss_cnt_next   = (loss_cnt_reg == '1) ? loss_cnt_reg : loss_cnt_reg + 1'b1;
              end
            end
            ST_FAULT: begin
              if (clear_fault[gi]) begin
                state_next     = ST_RST;
                rst_tmr_next   = '0;
                retry_tmr_next = '0;
                retry_cnt_next = '0;
              end
            end
            default: begin
              state_next = ST_DIS;
            end
          endcase
        end
      end

      // Outputs are registered from the next-state decode so they are glitch-free.
      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          state_reg      <= ST_DIS;
          rst_tmr_reg    <= '0;
          retry_tmr_reg  <= '0;
          stab_reg       <= '0;
          retry_cnt_reg  <= '0;
          loss_cnt_reg   <= '0;
          loss_pulse_reg <= 1'b0;
          pll_rst_reg    <= 1'b1;
          ch_ready_reg   <= 1'b0;
          ch_fault_reg   <= 1'b0;
        end else begin
          state_reg      <= state_next;
          rst_tmr_reg    <= rst_tmr_next;
          retry_tmr_reg  <= retry_tmr_next;
          stab_reg       <= stab_next;
          retry_cnt_reg  <= retry_cnt_next;
          loss_cnt_reg   <= loss_cnt_next;
          loss_pulse_reg <= loss_pulse_next;
          pll_rst_reg    <= (state_next == ST_DIS) || (state_next == ST_RST) ||
                            (state_next == ST_FAULT);
          ch_ready_reg   <= (state_next == ST_READY);
          ch_fault_reg   <= (state_next == ST_FAULT);
        end
      end

      assign pll_rst[gi]                   = pll_rst_reg;
      assign ch_ready[gi]                  = ch_ready_reg;
      assign ch_fault[gi]                  = ch_fault_reg;
      assign loss_pulse[gi]                = loss_pulse_reg;
      assign retry_cnt[gi*CNT_W +: CNT_W]  = retry_cnt_reg;
      assign loss_cnt[gi*CNT_W +: CNT_W]   = loss_cnt_reg;
    end
  endgenerate

  // Disabled channels are ignored; with nothing enabled the aggregate stays low.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      all_ready_reg <= 1'b0;
    end else begin
      all_ready_reg <= (|ch_enable) && (&(ch_ready | ~ch_enable));
    end
  end

  assign all_ready = all_ready_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised and directed bench for pll_lock_supervisor against a run-length
// based behavioural model of the channel sequencing rules.
module tb_pll_lock_supervisor;
  localparam int NCH = 2;
  localparam int RC  = 50;
  localparam int PC  = 4;
  localparam int LC  = 8;
  localparam int MR  = 3;
  localparam int CW  = 4;

  localparam int M_DIS = 0, M_RST = 1, M_SEARCH = 2, M_READY = 3, M_FAULT = 4;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_enable, locked_in, force_rst, clear_fault;
  logic [NCH-1:0] pll_rst, ch_ready, ch_fault, loss_pulse;
  logic           all_ready;
  logic [NCH*CW-1:0] retry_cnt, loss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: mode per channel plus elapsed-time and run-length counters.
  int m_mode[NCH];
  int m_rst_age[NCH];
  int m_age[NCH];
  int m_run[NCH];
  int m_retries[NCH];
  int m_losses[NCH];
  bit m_pulse[NCH];
  bit m_all;
  bit sync1[NCH];
  bit sync2[NCH];
  int quality[NCH];

  always #5 clk_in = ~clk_in;

  pll_lock_supervisor #(
    .NUM_CH(NCH), .RETRY_CYCLES(RC), .RST_PULSE_CYCLES(PC),
    .LOCK_STABLE_CYCLES(LC), .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ch_enable(ch_enable), .locked_in(locked_in),
    .force_rst(force_rst), .clear_fault(clear_fault), .pll_rst(pll_rst),
    .ch_ready(ch_ready), .ch_fault(ch_fault), .all_ready(all_ready),
    .loss_pulse(loss_pulse), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = M_DIS; m_rst_age[i] = 0; m_age[i] = 0; m_run[i] = 0;
      m_retries[i] = 0; m_losses[i] = 0; m_pulse[i] = 0;
      sync1[i] = 0; sync2[i] = 0;
    end
    m_all = 0;
  endtask

  task automatic start_rst(input int i);
    m_mode[i] = M_RST;
    m_rst_age[i] = 0;
  endtask

  task automatic model_step();
    bit na;
    bit ls;
    na = (ch_enable != '0);
    for (int i = 0; i < NCH; i++)
      if (ch_enable[i] && m_mode[i] != M_READY) na = 0;
    m_all = na;
    for (int i = 0; i < NCH; i++) begin
      ls = sync2[i];
      m_pulse[i] = 0;
      if (!ch_enable[i]) begin
        m_mode[i] = M_DIS;
      end else if (force_rst[i] && m_mode[i] != M_DIS) begin
        if (m_mode[i] == M_FAULT) m_retries[i] = 0;
        start_rst(i);
      end else begin
        case (m_mode[i])
          M_DIS: begin
            m_retries[i] = 0;
            start_rst(i);
          end
          M_RST: begin
            m_rst_age[i]++;
            if (m_rst_age[i] == PC) begin
              m_mode[i] = M_SEARCH; m_age[i] = 0; m_run[i] = 0;
            end
          end
          M_SEARCH: begin
            m_age[i]++;
            if (m_age[i] == RC) begin
              m_retries[i] = (m_retries[i] < 15) ? m_retries[i] + 1 : 15;
              if (MR != 0 && m_retries[i] >= MR) m_mode[i] = M_FAULT;
              else start_rst(i);
            end else begin
              m_run[i] = ls ? m_run[i] + 1 : 0;
              if (m_run[i] == LC + 1) begin
                m_mode[i] = M_READY;
                m_retries[i] = 0;
              end
            end
          end
          M_READY: begin
            if (!ls) begin
              m_pulse[i] = 1;
              m_losses[i] = (m_losses[i] < 15) ? m_losses[i] + 1 : 15;
              start_rst(i);
            end
          end
          default: begin
            if (clear_fault[i]) begin
              m_retries[i] = 0;
              start_rst(i);
            end
          end
        endcase
      end
      sync2[i] = sync1[i];
      sync1[i] = locked_in[i];
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e_rst, e_rdy, e_flt, e_lp;
    logic [NCH*CW-1:0] e_rc, e_lc;
    for (int i = 0; i < NCH; i++) begin
      e_rst[i] = (m_mode[i] == M_DIS) || (m_mode[i] == M_RST) || (m_mode[i] == M_FAULT);
      e_rdy[i] = (m_mode[i] == M_READY);
      e_flt[i] = (m_mode[i] == M_FAULT);
      e_lp[i]  = m_pulse[i];
      e_rc[i*CW +: CW] = CW'(m_retries[i]);
      e_lc[i*CW +: CW] = CW'(m_losses[i]);
    end
    chk("pll_rst", 32'(pll_rst), 32'(e_rst));
    chk("ch_ready", 32'(ch_ready), 32'(e_rdy));
    chk("ch_fault", 32'(ch_fault), 32'(e_flt));
    chk("loss_pulse", 32'(loss_pulse), 32'(e_lp));
    chk("all_ready", 32'(all_ready), 32'(m_all));
    chk("retry_cnt", 32'(retry_cnt), 32'(e_rc));
    chk("loss_cnt", 32'(loss_cnt), 32'(e_lc));
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_n) model_step();
    @(negedge clk_in);
    check_all();
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called right after a falling edge: reset asserts and releases before the next rising edge.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("arst_pll_rst", 32'(pll_rst), 32'h3);
    chk("arst_all_ready", 32'(all_ready), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    ch_enable = '0; locked_in = '0; force_rst = '0; clear_fault = '0;
    rst_n = 1'b0;
    quality[0] = 0; quality[1] = 0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all();
    chk("reset_pll_rst", 32'(pll_rst), 32'h3);
    chk("reset_ch_ready", 32'(ch_ready), 32'h0);
    chk("reset_loss_cnt", 32'(loss_cnt), 32'h0);

    // No lock at all: three timeouts then FAULT on edge 1 + 3*(4+50).
    ch_enable = 2'b11;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 400 && !ch_fault[0]; k++) begin
      tick();
      n++;
    end
    chk("fault_edge_count", 32'(n), 32'd163);
    chk("fault_retry_cnt", 32'(retry_cnt), 32'h33);
    chk("fault_pll_rst", 32'(pll_rst), 32'h3);
    chk("fault_all_ready", 32'(all_ready), 32'h0);

    // Leave FAULT on ch0, then lock 10 cycles after pll_rst falls.
    clear_fault[0] = 1'b1;
    tick();
    clear_fault[0] = 1'b0;
    chk("clear_retry_cnt0", 32'(retry_cnt[3:0]), 32'h0);
    chk("clear_pll_rst0", 32'(pll_rst[0]), 32'h1);
    tick_n(3);
    chk("clear_pulse_hi", 32'(pll_rst[0]), 32'h1);
    tick();
    chk("clear_pulse_lo", 32'(pll_rst[0]), 32'h0);
    tick_n(10);
    locked_in[0] = 1'b1;
    tick_n(10);
    chk("lat_not_yet", 32'(ch_ready[0]), 32'h0);
    tick();
    chk("lat_ready", 32'(ch_ready[0]), 32'h1);
    chk("lat_retry0", 32'(retry_cnt[3:0]), 32'h0);
    chk("lat_all_ready", 32'(all_ready), 32'h0);

    // Bring ch1 up; all_ready follows one cycle after ch_ready.
    clear_fault[1] = 1'b1;
    locked_in[1] = 1'b1;
    tick();
    clear_fault[1] = 1'b0;
    for (int k = 0; k < 40 && !ch_ready[1]; k++) tick();
    chk("ch1_ready", 32'(ch_ready[1]), 32'h1);
    chk("all_ready_lags", 32'(all_ready), 32'h0);
    tick();
    chk("all_ready_rise", 32'(all_ready), 32'h1);

    // Lock loss on ch1.
    locked_in[1] = 1'b0;
    tick_n(2);
    chk("loss_still_ready", 32'(ch_ready[1]), 32'h1);
    tick();
    chk("loss_ready_fall", 32'(ch_ready[1]), 32'h0);
    chk("loss_pll_rst", 32'(pll_rst[1]), 32'h1);
    chk("loss_pulse", 32'(loss_pulse), 32'h2);
    chk("loss_cnt1", 32'(loss_cnt), 32'h10);
    tick();
    chk("loss_pulse_end", 32'(loss_pulse), 32'h0);
    tick_n(2);
    chk("loss_rst_hi", 32'(pll_rst[1]), 32'h1);
    tick();
    chk("loss_rst_lo", 32'(pll_rst[1]), 32'h0);
    locked_in[1] = 1'b1;

    // Forced restart of ch0 from READY: no loss accounting.
    force_rst[0] = 1'b1;
    locked_in[0] = 1'b0;
    tick();
    force_rst[0] = 1'b0;
    chk("force_no_pulse", 32'(loss_pulse[0]), 32'h0);
    chk("force_no_loss", 32'(loss_cnt[3:0]), 32'h0);
    tick_n(4);
    chk("force_wait", 32'(pll_rst[0]), 32'h0);

    // Late glitch: the retry window is not restarted, so timeout beats READY.
    tick_n(36);
    locked_in[0] = 1'b1;
    tick_n(5);
    locked_in[0] = 1'b0;
    tick_n(2);
    locked_in[0] = 1'b1;
    tick_n(6);
    chk("glitch_before_to", 32'(pll_rst[0]), 32'h0);
    tick();
    chk("glitch_timeout", 32'(pll_rst[0]), 32'h1);
    chk("glitch_retry", 32'(retry_cnt[3:0]), 32'h1);
    chk("glitch_no_ready", 32'(ch_ready[0]), 32'h0);
    for (int k = 0; k < 40 && !ch_ready[0]; k++) tick();
    chk("glitch_recover", 32'(ch_ready[0]), 32'h1);
    chk("glitch_retry_clr", 32'(retry_cnt[3:0]), 32'h0);

    // force_rst coinciding with a timeout.
    locked_in[0] = 1'b0;
    force_rst[0] = 1'b1;
    tick();
    force_rst[0] = 1'b0;
    tick_n(4);
    chk("fto_wait", 32'(pll_rst[0]), 32'h0);
    tick_n(49);
    force_rst[0] = 1'b1;
    tick();
    force_rst[0] = 1'b0;
    chk("fto_rst", 32'(pll_rst[0]), 32'h1);
    chk("fto_retry", 32'(retry_cnt[3:0]), 32'h0);
    tick_n(3);
    chk("fto_pulse_hi", 32'(pll_rst[0]), 32'h1);
    tick();
    chk("fto_pulse_lo", 32'(pll_rst[0]), 32'h0);

    // Async reset while ch0 is stabilising.
    locked_in[0] = 1'b1;
    tick_n(6);
    async_reset();
    chk("arst_loss_cnt", 32'(loss_cnt), 32'h0);

    // Disable ch1 while it waits; all_ready then ignores it.
    locked_in = 2'b01;
    tick_n(10);
    chk("dis_ch1_wait", 32'(pll_rst[1]), 32'h0);
    ch_enable = 2'b01;
    tick();
    chk("dis_ch1_rst", 32'(pll_rst[1]), 32'h1);
    chk("dis_ch1_ready", 32'(ch_ready[1]), 32'h0);
    for (int k = 0; k < 40 && !ch_ready[0]; k++) tick();
    tick();
    chk("dis_all_ready", 32'(all_ready), 32'h1);
    ch_enable = 2'b00;
    tick_n(2);
    chk("none_all_ready", 32'(all_ready), 32'h0);
    chk("none_pll_rst", 32'(pll_rst), 32'h3);

    // Randomised phase: each channel has a lock quality that drifts over time.
    ch_enable = 2'b11;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(1999) == 0) async_reset();
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(399) == 0) quality[i] = int'($urandom_range(2));
        case (quality[i])
          0: if ($urandom_range(31) == 0) locked_in[i] = ~locked_in[i];
          1: locked_in[i] = 1'b0;
          default: if ($urandom_range(3) == 0) locked_in[i] = ~locked_in[i];
        endcase
        if ($urandom_range(299) == 0) ch_enable[i] = ~ch_enable[i];
        force_rst[i]   = ($urandom_range(199) == 0);
        clear_fault[i] = ($urandom_range(39) == 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
